// File: rtl/alu_pkg.sv
// Shared ALU definitions: 6-bit op encoding, legality check and the ALU result record.
package alu_pkg;

  localparam int OP_W = 6;

  localparam logic [OP_W-1:0] ALU_ADD  = 6'h00;
  localparam logic [OP_W-1:0] ALU_SUB  = 6'h01;
  localparam logic [OP_W-1:0] ALU_SHL  = 6'h02;
  localparam logic [OP_W-1:0] ALU_LSR  = 6'h03;
  localparam logic [OP_W-1:0] ALU_ASR  = 6'h04;
  localparam logic [OP_W-1:0] ALU_OR   = 6'h05;
  localparam logic [OP_W-1:0] ALU_AND  = 6'h06;
  localparam logic [OP_W-1:0] ALU_NOR  = 6'h07;
  localparam logic [OP_W-1:0] ALU_XOR  = 6'h08;
  localparam logic [OP_W-1:0] ALU_SLTU = 6'h09;
  localparam logic [OP_W-1:0] ALU_SLT  = 6'h0A;

  // The requester tag is appended by each user, since its width is a per-instance parameter.
  typedef struct packed {
    logic [31:0] res;
    logic        z;
    logic        n;
    logic        err;
  } alu_rsp_t;

  function automatic logic is_legal_op(input logic [OP_W-1:0] op);
    case (op)
      ALU_ADD, ALU_SUB, ALU_SHL, ALU_LSR, ALU_ASR, ALU_OR,
      ALU_AND, ALU_NOR, ALU_XOR, ALU_SLTU, ALU_SLT: is_legal_op = 1'b1;
      default:                                      is_legal_op = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/alu.sv
// Combinational 32-bit ALU; illegal ops return a clean all-zero result with err set.
module alu
  import alu_pkg::*;
(
  input  logic [OP_W-1:0] op,
  input  logic [31:0]     a,
  input  logic [31:0]     b,
  output alu_rsp_t        rsp
);

  logic signed [31:0] sa;
  logic signed [31:0] sb;
  logic        [31:0] res;
  logic               legal;

  assign sa    = a;
  assign sb    = b;
  assign legal = is_legal_op(op);

  always_comb begin
    res = '0;
    case (op)
      ALU_ADD:  res = a + b;
      ALU_SUB:  res = a - b;
      ALU_SHL:  res = a << b[4:0];
      ALU_LSR:  res = a >> b[4:0];
      ALU_ASR:  res = sa >>> b[4:0];
      ALU_OR:   res = a | b;
      ALU_AND:  res = a & b;
      ALU_NOR:  res = ~(a | b);
      ALU_XOR:  res = a ^ b;
      ALU_SLTU: res = {31'd0, (a < b)};
      ALU_SLT:  res = {31'd0, (sa < sb)};
      default:  res = '0;
    endcase
  end

  // Flags are forced low on an illegal op so a zero result is not mistaken for z=1.
  assign rsp.res = res;
  assign rsp.z   = legal && (res == 32'd0);
  assign rsp.n   = legal && res[31];
  assign rsp.err = !legal;

endmodule

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter; priority passes to the other port after every grant.
module rr_arb2 (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] eligible,
  output logic [1:0] grant
);

  logic prio_q;

  always_comb begin
    grant = eligible;
    if (&eligible) grant = prio_q ? 2'b10 : 2'b01;
  end

  always_ff @(posedge clk) begin
    if (!rst_n)      prio_q <= 1'b0;
    else if (|grant) prio_q <= grant[0];
  end

endmodule

// File: rtl/alu_share_arb.sv
// Shares one ALU between two requesters with round-robin arbitration and a registered
// response slot per port. Optional ALU_ARB_STATS_EN adds saturating grant/conflict counters.
module alu_share_arb
  import alu_pkg::*;
#(
  parameter int TAG_W  = 4,
  parameter int STAT_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,

  input  logic              req0_valid_i,
  output logic              req0_ready_o,
  input  logic [31:0]       req0_opr_a_i,
  input  logic [31:0]       req0_opr_b_i,
  input  logic [OP_W-1:0]   req0_op_i,
  input  logic [TAG_W-1:0]  req0_tag_i,
  output logic              rsp0_valid_o,
  input  logic              rsp0_ready_i,
  output logic [31:0]       rsp0_res_o,
  output logic              rsp0_z_o,
  output logic              rsp0_n_o,
  output logic              rsp0_err_o,
  output logic [TAG_W-1:0]  rsp0_tag_o,

  input  logic              req1_valid_i,
  output logic              req1_ready_o,
  input  logic [31:0]       req1_opr_a_i,
  input  logic [31:0]       req1_opr_b_i,
  input  logic [OP_W-1:0]   req1_op_i,
  input  logic [TAG_W-1:0]  req1_tag_i,
  output logic              rsp1_valid_o,
  input  logic              rsp1_ready_i,
  output logic [31:0]       rsp1_res_o,
  output logic              rsp1_z_o,
  output logic              rsp1_n_o,
  output logic              rsp1_err_o,
  output logic [TAG_W-1:0]  rsp1_tag_o
`ifdef ALU_ARB_STATS_EN
  ,
  output logic [STAT_W-1:0] stat_grant0_o,
  output logic [STAT_W-1:0] stat_grant1_o,
  output logic [STAT_W-1:0] stat_conflict_o
`endif
);

  localparam logic [0:0] SLOT_EMPTY = 1'b0;
  localparam logic [0:0] SLOT_FULL  = 1'b1;

  typedef struct packed {
    alu_rsp_t         alu;
    logic [TAG_W-1:0] tag;
  } rsp_t;

  logic [1:0]       req_valid;
  logic [1:0]       rsp_ready;
  logic [1:0]       eligible;
  logic [1:0]       grant;

  logic [OP_W-1:0]  alu_op_p0;
  logic [31:0]      alu_a_p0;
  logic [31:0]      alu_b_p0;
  logic [TAG_W-1:0] tag_p0;
  alu_rsp_t         alu_out_p0;

  logic [0:0]       slot_st_p1 [2];
  rsp_t             rsp_p1     [2];

  assign req_valid = {req1_valid_i, req0_valid_i};
  assign rsp_ready = {rsp1_ready_i, rsp0_ready_i};

  // A full slot can still accept when it is being drained in the same cycle.
  always_comb begin
    eligible = '0;
    for (int i = 0; i < 2; i++) begin
      eligible[i] = rst_n && req_valid[i] &&
                    ((slot_st_p1[i] == SLOT_EMPTY) || rsp_ready[i]);
    end
  end

  rr_arb2 u_arb (
    .clk      (clk),
    .rst_n    (rst_n),
    .eligible (eligible),
    .grant    (grant)
  );

  assign req0_ready_o = grant[0];
  assign req1_ready_o = grant[1];

  always_comb begin
    alu_op_p0 = req0_op_i;
    alu_a_p0  = req0_opr_a_i;
    alu_b_p0  = req0_opr_b_i;
    tag_p0    = req0_tag_i;
    if (grant[1]) begin
      alu_op_p0 = req1_op_i;
      alu_a_p0  = req1_opr_a_i;
      alu_b_p0  = req1_opr_b_i;
      tag_p0    = req1_tag_i;
    end
  end

  alu u_alu (
    .op  (alu_op_p0),
    .a   (alu_a_p0),
    .b   (alu_b_p0),
    .rsp (alu_out_p0)
  );

  // ---- stage p0 -> p1: response slots ----
  always_ff @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (!rst_n) begin
        slot_st_p1[i] <= SLOT_EMPTY;
        rsp_p1[i]     <= '0;
      end else if (grant[i]) begin
        slot_st_p1[i] <= SLOT_FULL;
        rsp_p1[i]     <= '{alu: alu_out_p0, tag: tag_p0};
      end else if (rsp_ready[i]) begin
        slot_st_p1[i] <= SLOT_EMPTY;
      end
    end
  end

  assign rsp0_valid_o = (slot_st_p1[0] == SLOT_FULL);
  assign rsp0_res_o   = rsp_p1[0].alu.res;
  assign rsp0_z_o     = rsp_p1[0].alu.z;
  assign rsp0_n_o     = rsp_p1[0].alu.n;
  assign rsp0_err_o   = rsp_p1[0].alu.err;
  assign rsp0_tag_o   = rsp_p1[0].tag;

  assign rsp1_valid_o = (slot_st_p1[1] == SLOT_FULL);
  assign rsp1_res_o   = rsp_p1[1].alu.res;
  assign rsp1_z_o     = rsp_p1[1].alu.z;
  assign rsp1_n_o     = rsp_p1[1].alu.n;
  assign rsp1_err_o   = rsp_p1[1].alu.err;
  assign rsp1_tag_o   = rsp_p1[1].tag;

`ifdef ALU_ARB_STATS_EN
  function automatic logic [STAT_W-1:0] sat_inc(input logic [STAT_W-1:0] c);
    return (&c) ? c : c + STAT_W'(1);
  endfunction

  logic [STAT_W-1:0] grant0_cnt;
  logic [STAT_W-1:0] grant1_cnt;
  logic [STAT_W-1:0] conflict_cnt;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      grant0_cnt   <= '0;
      grant1_cnt   <= '0;
      conflict_cnt <= '0;
    end else begin
      if (grant[0])   grant0_cnt   <= sat_inc(grant0_cnt);
      if (grant[1])   grant1_cnt   <= sat_inc(grant1_cnt);
      if (&eligible)  conflict_cnt <= sat_inc(conflict_cnt);
    end
  end

  assign stat_grant0_o   = grant0_cnt;
  assign stat_grant1_o   = grant1_cnt;
  assign stat_conflict_o = conflict_cnt;
`endif

endmodule

// File: tb/tb_alu_share_arb.sv
// Directed self-checking bench for alu_share_arb (stat checks only when ALU_ARB_STATS_EN is defined).
module tb_alu_share_arb;
  import alu_pkg::*;

  localparam int TAG_W  = 4;
  localparam int STAT_W = 16;

  logic              clk;
  logic              rst_n;
  logic              req0_valid_i, req1_valid_i;
  logic              req0_ready_o, req1_ready_o;
  logic [31:0]       req0_opr_a_i, req0_opr_b_i, req1_opr_a_i, req1_opr_b_i;
  logic [5:0]        req0_op_i, req1_op_i;
  logic [TAG_W-1:0]  req0_tag_i, req1_tag_i;
  logic              rsp0_valid_o, rsp1_valid_o;
  logic              rsp0_ready_i, rsp1_ready_i;
  logic [31:0]       rsp0_res_o, rsp1_res_o;
  logic              rsp0_z_o, rsp0_n_o, rsp0_err_o, rsp1_z_o, rsp1_n_o, rsp1_err_o;
  logic [TAG_W-1:0]  rsp0_tag_o, rsp1_tag_o;
`ifdef ALU_ARB_STATS_EN
  logic [STAT_W-1:0] stat_grant0_o, stat_grant1_o, stat_conflict_o;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  alu_share_arb #(.TAG_W(TAG_W), .STAT_W(STAT_W)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .req0_valid_i (req0_valid_i),
    .req0_ready_o (req0_ready_o),
    .req0_opr_a_i (req0_opr_a_i),
    .req0_opr_b_i (req0_opr_b_i),
    .req0_op_i    (req0_op_i),
    .req0_tag_i   (req0_tag_i),
    .rsp0_valid_o (rsp0_valid_o),
    .rsp0_ready_i (rsp0_ready_i),
    .rsp0_res_o   (rsp0_res_o),
    .rsp0_z_o     (rsp0_z_o),
    .rsp0_n_o     (rsp0_n_o),
    .rsp0_err_o   (rsp0_err_o),
    .rsp0_tag_o   (rsp0_tag_o),
    .req1_valid_i (req1_valid_i),
    .req1_ready_o (req1_ready_o),
    .req1_opr_a_i (req1_opr_a_i),
    .req1_opr_b_i (req1_opr_b_i),
    .req1_op_i    (req1_op_i),
    .req1_tag_i   (req1_tag_i),
    .rsp1_valid_o (rsp1_valid_o),
    .rsp1_ready_i (rsp1_ready_i),
    .rsp1_res_o   (rsp1_res_o),
    .rsp1_z_o     (rsp1_z_o),
    .rsp1_n_o     (rsp1_n_o),
    .rsp1_err_o   (rsp1_err_o),
    .rsp1_tag_o   (rsp1_tag_o)
`ifdef ALU_ARB_STATS_EN
    ,
    .stat_grant0_o   (stat_grant0_o),
    .stat_grant1_o   (stat_grant1_o),
    .stat_conflict_o (stat_conflict_o)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected end of test");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int p, input logic v, input logic [5:0] op,
                         input logic [31:0] a, input logic [31:0] b, input logic [3:0] tag);
    if (p == 0) begin
      req0_valid_i = v; req0_op_i = op; req0_opr_a_i = a; req0_opr_b_i = b; req0_tag_i = tag;
    end else begin
      req1_valid_i = v; req1_op_i = op; req1_opr_a_i = a; req1_opr_b_i = b; req1_tag_i = tag;
    end
  endtask

  task automatic check_rsp(input string nm, input int p, input logic [31:0] res,
                           input logic z, input logic n, input logic err, input logic [3:0] tag);
    if (p == 0) begin
      check({nm, " rsp0_valid"}, rsp0_valid_o, 1);
      check({nm, " rsp0_res"},   rsp0_res_o,   res);
      check({nm, " rsp0_z"},     rsp0_z_o,     z);
      check({nm, " rsp0_n"},     rsp0_n_o,     n);
      check({nm, " rsp0_err"},   rsp0_err_o,   err);
      check({nm, " rsp0_tag"},   rsp0_tag_o,   tag);
    end else begin
      check({nm, " rsp1_valid"}, rsp1_valid_o, 1);
      check({nm, " rsp1_res"},   rsp1_res_o,   res);
      check({nm, " rsp1_z"},     rsp1_z_o,     z);
      check({nm, " rsp1_n"},     rsp1_n_o,     n);
      check({nm, " rsp1_err"},   rsp1_err_o,   err);
      check({nm, " rsp1_tag"},   rsp1_tag_o,   tag);
    end
  endtask

  // One request on port p alone, response checked one cycle later, then drained.
  task automatic issue_single(input string nm, input int p, input logic [5:0] op,
                              input logic [31:0] a, input logic [31:0] b, input logic [3:0] tag,
                              input logic [31:0] res, input logic z, input logic n, input logic err);
    set_req(p, 1'b1, op, a, b, tag);
    set_req(1 - p, 1'b0, 6'h00, 32'h0, 32'h0, 4'h0);
    rsp0_ready_i = 1'b1;
    rsp1_ready_i = 1'b1;
    #1;
    check({nm, " ready0"}, req0_ready_o, (p == 0));
    check({nm, " ready1"}, req1_ready_o, (p == 1));
    step();
    set_req(p, 1'b0, 6'h00, 32'h0, 32'h0, 4'h0);
    check_rsp(nm, p, res, z, n, err, tag);
    step();
    check({nm, " drained"}, (p == 0) ? rsp0_valid_o : rsp1_valid_o, 0);
  endtask

  initial begin
    rst_n = 1'b0;
    rsp0_ready_i = 1'b0;
    rsp1_ready_i = 1'b0;
    set_req(0, 1'b1, ALU_ADD, 32'd1, 32'd1, 4'h1);
    set_req(1, 1'b1, ALU_ADD, 32'd1, 32'd1, 4'h1);
    step();
    step();
    check("reset ready0", req0_ready_o, 0);
    check("reset ready1", req1_ready_o, 0);
    check("reset rsp0_valid", rsp0_valid_o, 0);
    check("reset rsp1_valid", rsp1_valid_o, 0);
    check("reset rsp0_res", rsp0_res_o, 0);
    check("reset rsp1_tag", rsp1_tag_o, 0);

    rst_n = 1'b1;
    issue_single("add", 0, ALU_ADD, 32'd5, 32'd7, 4'd3, 32'd12, 1'b0, 1'b0, 1'b0);
    issue_single("subneg", 1, ALU_SUB, 32'd3, 32'd5, 4'd9, 32'hFFFF_FFFE, 1'b0, 1'b1, 1'b0);
    issue_single("shl", 0, ALU_SHL, 32'd1, 32'd4, 4'd1, 32'd16, 1'b0, 1'b0, 1'b0);
    issue_single("illegal", 1, 6'h3F, 32'hDEAD, 32'hBEEF, 4'd5, 32'd0, 1'b0, 1'b0, 1'b1);
    issue_single("asr", 0, ALU_ASR, 32'h8000_0000, 32'd4, 4'd2, 32'hF800_0000, 1'b0, 1'b1, 1'b0);
    issue_single("sltu", 1, ALU_SLTU, 32'd1, 32'hFFFF_FFFF, 4'd4, 32'd1, 1'b0, 1'b0, 1'b0);

    // Conflict: priority is back at port 0 after six alternating single grants.
    set_req(0, 1'b1, ALU_SLT, 32'hFFFF_FFFF, 32'd1, 4'd1);
    set_req(1, 1'b1, ALU_SUB, 32'd3, 32'd3, 4'd2);
    for (int k = 0; k < 4; k++) begin
      #1;
      check($sformatf("alt%0d ready0", k), req0_ready_o, (k % 2 == 0));
      check($sformatf("alt%0d ready1", k), req1_ready_o, (k % 2 == 1));
      step();
      check($sformatf("alt%0d rsp0_valid", k), rsp0_valid_o, (k % 2 == 0));
      check($sformatf("alt%0d rsp1_valid", k), rsp1_valid_o, (k % 2 == 1));
      if (k % 2 == 0) check_rsp($sformatf("alt%0d slt", k), 0, 32'd1, 1'b0, 1'b0, 1'b0, 4'd1);
      else            check_rsp($sformatf("alt%0d sub", k), 1, 32'd0, 1'b1, 1'b0, 1'b0, 4'd2);
    end
    set_req(0, 1'b0, 6'h00, 32'h0, 32'h0, 4'h0);
    set_req(1, 1'b0, 6'h00, 32'h0, 32'h0, 4'h0);
    step();

    // Back-pressure on port 0; port 1 keeps flowing; port 0 operand changes are ignored.
    rsp0_ready_i = 1'b0;
    rsp1_ready_i = 1'b1;
    set_req(0, 1'b1, ALU_ADD, 32'd1, 32'd2, 4'd4);
    for (int k = 0; k < 4; k++) begin
      set_req(1, 1'b1, ALU_ADD, 32'd10, k, 4'd6);
      if (k > 0) set_req(0, 1'b1, ALU_ADD, 32'd1, 32'd20, 4'd8);
      #1;
      check($sformatf("bp%0d ready0", k), req0_ready_o, (k == 0));
      check($sformatf("bp%0d ready1", k), req1_ready_o, (k != 0));
      step();
      check_rsp($sformatf("bp%0d hold", k), 0, 32'd3, 1'b0, 1'b0, 1'b0, 4'd4);
      check($sformatf("bp%0d rsp1_valid", k), rsp1_valid_o, (k != 0));
      if (k != 0) check($sformatf("bp%0d rsp1_res", k), rsp1_res_o, 32'd10 + k);
    end
    rsp0_ready_i = 1'b1;
    set_req(1, 1'b1, ALU_ADD, 32'd10, 32'd7, 4'd6);
    #1;
    check("release ready0", req0_ready_o, 1);
    check("release ready1", req1_ready_o, 0);
    check("release rsp0_valid pre", rsp0_valid_o, 1);
    step();
    check_rsp("release", 0, 32'd21, 1'b0, 1'b0, 1'b0, 4'd8);
    check("release rsp1_valid", rsp1_valid_o, 0);

    // Reset while rsp0 is full and priority favours port 1.
    set_req(0, 1'b0, 6'h00, 32'h0, 32'h0, 4'h0);
    set_req(1, 1'b0, 6'h00, 32'h0, 32'h0, 4'h0);
    rsp0_ready_i = 1'b0;
    step();
    check("prerst rsp0_valid", rsp0_valid_o, 1);
    check("prerst rsp0_res", rsp0_res_o, 32'd21);
    rst_n = 1'b0;
    step();
    set_req(0, 1'b1, ALU_ADD, 32'd5, 32'd7, 4'd3);
    set_req(1, 1'b1, ALU_SUB, 32'd3, 32'd3, 4'd2);
    rsp0_ready_i = 1'b1;
    #1;
    check("midrst rsp0_valid", rsp0_valid_o, 0);
    check("midrst rsp0_res", rsp0_res_o, 0);
    check("midrst rsp0_tag", rsp0_tag_o, 0);
    check("midrst ready0", req0_ready_o, 0);
    check("midrst ready1", req1_ready_o, 0);
    rst_n = 1'b1;
    #1;
    check("postrst ready0", req0_ready_o, 1);
    check("postrst ready1", req1_ready_o, 0);
    step();
    check_rsp("postrst", 0, 32'd12, 1'b0, 1'b0, 1'b0, 4'd3);

`ifdef ALU_ARB_STATS_EN
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    check("stat rst grant0", stat_grant0_o, 0);
    check("stat rst conflict", stat_conflict_o, 0);
    for (int k = 0; k < 10; k++) step();
    set_req(0, 1'b0, 6'h00, 32'h0, 32'h0, 4'h0);
    set_req(1, 1'b0, 6'h00, 32'h0, 32'h0, 4'h0);
    #1;
    check("stat grant0", stat_grant0_o, 5);
    check("stat grant1", stat_grant1_o, 5);
    check("stat conflict", stat_conflict_o, 10);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
